// File: rtl/bmem_line_adapter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bmem_line_adapter_if : cache-line side and burst-memory side bus |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface bmem_line_adapter_if #(
  parameter int DATA_W = 64,
  parameter int BEATS  = 4
);
  localparam int LINE_W = DATA_W * BEATS;

  logic [31:0]       line_address;
  logic              line_read;
  logic              line_write;
  logic [LINE_W-1:0] line_wdata;
  logic [LINE_W-1:0] line_rdata;
  logic              line_resp;
  logic [31:0]       bmem_address;
  logic              bmem_read;
  logic              bmem_write;
  logic [DATA_W-1:0] bmem_wdata;
  logic [DATA_W-1:0] bmem_rdata;
  logic              bmem_resp;

  // master is the adapter; slave is the surrounding cache + memory
  modport master (
    input  line_address, line_read, line_write, line_wdata, bmem_rdata, bmem_resp,
    output line_rdata, line_resp, bmem_address, bmem_read, bmem_write, bmem_wdata
  );

  modport slave (
    output line_address, line_read, line_write, line_wdata, bmem_rdata, bmem_resp,
    input  line_rdata, line_resp, bmem_address, bmem_read, bmem_write, bmem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/bmem_line_adapter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bmem_line_adapter : splits cache lines into DATA_W memory bursts |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module bmem_line_adapter #(
  parameter int DATA_W = 64,
  parameter int BEATS  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bmem_line_adapter_if.master    bus
);
  localparam int              LINE_W   = DATA_W * BEATS;
  localparam int              CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [31:0]     OFF_MASK = 32'(LINE_W / 8 - 1);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_DATA = 3'd2,
    WR_DATA = 3'd3,
    WR_WAIT = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  beat_cnt;
  logic [CNT_W-1:0]  next_cnt;
  logic [LINE_W-1:0] wbuf;

  assign next_cnt = beat_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      beat_cnt         <= '0;
      wbuf             <= '0;
      bus.bmem_read    <= 1'b0;
      bus.bmem_write   <= 1'b0;
      bus.line_resp    <= 1'b0;
      bus.bmem_address <= '0;
      bus.bmem_wdata   <= '0;
      bus.line_rdata   <= '0;
    end else begin
      bus.bmem_read <= 1'b0;
      bus.line_resp <= 1'b0;
      case (state)
        IDLE: begin
          // write wins when both requests are raised together
          if (bus.line_write) begin
            bus.bmem_address <= bus.line_address & ~OFF_MASK;
            wbuf             <= bus.line_wdata;
            bus.bmem_wdata   <= bus.line_wdata[DATA_W-1:0];
            bus.bmem_write   <= 1'b1;
            beat_cnt         <= '0;
            state            <= WR_DATA;
          end else if (bus.line_read) begin
            bus.bmem_address <= bus.line_address & ~OFF_MASK;
            bus.bmem_read    <= 1'b1;
            beat_cnt         <= '0;
            state            <= RD_REQ;
          end
        end
        RD_REQ: state <= RD_DATA;
        RD_DATA: begin
          if (bus.bmem_resp) begin
            for (int k = 0; k < BEATS; k++) begin
              if (beat_cnt == CNT_W'(k))
                bus.line_rdata[k*DATA_W +: DATA_W] <= bus.bmem_rdata;
            end
            if (beat_cnt == LAST) begin
              beat_cnt      <= '0;
              bus.line_resp <= 1'b1;
              state         <= DONE;
            end else begin
              beat_cnt <= next_cnt;
            end
          end
        end
        WR_DATA: begin
          // beat_cnt names the beat currently on bmem_wdata
          if (beat_cnt == LAST) begin
            beat_cnt       <= '0;
            bus.bmem_write <= 1'b0;
            state          <= WR_WAIT;
          end else begin
            beat_cnt <= next_cnt;
            for (int k = 0; k < BEATS; k++) begin
              if (next_cnt == CNT_W'(k))
                bus.bmem_wdata <= wbuf[k*DATA_W +: DATA_W];
            end
          end
        end
        WR_WAIT: begin
          if (bus.bmem_resp) begin
            bus.line_resp <= 1'b1;
            state         <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_bmem_line_adapter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_bmem_line_adapter : directed bench for bmem_line_adapter      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_bmem_line_adapter;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   read_pulses;
  int   resp_pulses;

  bmem_line_adapter_if #(.DATA_W(64), .BEATS(4)) bus ();

  bmem_line_adapter #(.DATA_W(64), .BEATS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.bmem_read === 1'b1) read_pulses = read_pulses + 1;
    if (bus.line_resp === 1'b1) resp_pulses = resp_pulses + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one read burst; gap idle cycles precede every beat; keep leaves line_read high in DONE
  task automatic read_burst(input logic [31:0] addr, input logic [31:0] exp_addr,
                            input logic [255:0] line, input int gap, input bit keep);
    int lat;
    bus.line_address = addr;
    bus.line_read    = 1'b1;
    step();
    lat = 1;
    chk("rd_bmem_read", {255'd0, bus.bmem_read}, 256'd1);
    chk("rd_address", {224'd0, bus.bmem_address}, {224'd0, exp_addr});
    step();
    lat++;
    chk("rd_read_one_cycle", {255'd0, bus.bmem_read}, 256'd0);
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gap; g++) begin
        bus.bmem_resp = 1'b0;
        step();
        lat++;
      end
      chk("rd_no_early_resp", {255'd0, bus.line_resp}, 256'd0);
      bus.bmem_resp  = 1'b1;
      bus.bmem_rdata = line[k*64 +: 64];
      step();
      lat++;
    end
    bus.bmem_resp = 1'b0;
    if (!keep) bus.line_read = 1'b0;
    chk("rd_line_resp", {255'd0, bus.line_resp}, 256'd1);
    chk("rd_line_rdata", bus.line_rdata, line);
    chk("rd_latency", 256'(lat), 256'(6 + 4 * gap));
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [255:0] line,
                             input int wait_cyc, input bit also_read);
    int lat;
    bus.line_address = addr;
    bus.line_wdata   = line;
    bus.line_write   = 1'b1;
    bus.line_read    = also_read;
    step();
    lat = 1;
    for (int k = 0; k < 4; k++) begin
      chk("wr_bmem_write", {255'd0, bus.bmem_write}, 256'd1);
      chk("wr_bmem_wdata", {192'd0, bus.bmem_wdata}, {192'd0, line[k*64 +: 64]});
      step();
      lat++;
    end
    chk("wr_write_low", {255'd0, bus.bmem_write}, 256'd0);
    chk("wr_address", {224'd0, bus.bmem_address}, {224'd0, addr & 32'hFFFF_FFE0});
    for (int w = 0; w < wait_cyc - 1; w++) begin
      step();
      lat++;
      chk("wr_wait_no_resp", {255'd0, bus.line_resp}, 256'd0);
    end
    bus.bmem_resp = 1'b1;
    step();
    lat++;
    bus.bmem_resp  = 1'b0;
    bus.line_write = 1'b0;
    bus.line_read  = 1'b0;
    chk("wr_line_resp", {255'd0, bus.line_resp}, 256'd1);
    chk("wr_latency", 256'(lat), 256'(4 + wait_cyc + 1));
  endtask

  initial begin
    logic [255:0] line_a;
    logic [255:0] line_w;
    logic [255:0] line_b;
    logic [255:0] line_c;
    int           base;
    checks = 0;
    errors = 0;
    read_pulses = 0;
    resp_pulses = 0;
    rst_n = 1'b0;
    bus.line_address = '0;
    bus.line_read    = 1'b0;
    bus.line_write   = 1'b0;
    bus.line_wdata   = '0;
    bus.bmem_rdata   = '0;
    bus.bmem_resp    = 1'b0;
    line_a = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    line_w = {64'hD3D3_0003_0303_D3D3, 64'hD2D2_0002_0202_D2D2,
              64'hD1D1_0001_0101_D1D1, 64'hD0D0_0000_0000_D0D0};
    line_b = {64'hDEAD_BEEF_0000_0004, 64'hCAFE_F00D_0000_0003,
              64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};
    line_c = {64'hA5A5_A5A5_0000_0003, 64'h5A5A_5A5A_0000_0002,
              64'h0F0F_0F0F_0000_0001, 64'hF0F0_F0F0_0000_0000};

    step();
    step();
    chk("rst_line_resp", {255'd0, bus.line_resp}, 256'd0);
    chk("rst_bmem_read", {255'd0, bus.bmem_read}, 256'd0);
    chk("rst_bmem_write", {255'd0, bus.bmem_write}, 256'd0);
    chk("rst_bmem_address", {224'd0, bus.bmem_address}, 256'd0);
    chk("rst_line_rdata", bus.line_rdata, 256'd0);
    rst_n = 1'b1;

    // basic read, back-to-back beats
    read_burst(32'h1234_5678, 32'h1234_5660, line_a, 0, 1'b0);
    step();
    chk("rd_resp_one_cycle", {255'd0, bus.line_resp}, 256'd0);

    // write with bmem_resp three cycles after the last beat
    write_burst(32'h0000_0040, line_w, 3, 1'b0);
    step();
    chk("wr_resp_one_cycle", {255'd0, bus.line_resp}, 256'd0);

    // simultaneous read and write: write wins, no bmem_read
    base = read_pulses;
    write_burst(32'h0000_1234, line_b, 1, 1'b1);
    step();
    chk("prio_no_read", 256'(read_pulses - base), 256'd0);

    // spurious bmem_resp in IDLE, then gapped read
    bus.bmem_resp = 1'b1;
    step();
    bus.bmem_resp = 1'b0;
    chk("spur_no_resp", {255'd0, bus.line_resp}, 256'd0);
    chk("spur_no_read", {255'd0, bus.bmem_read}, 256'd0);
    step();
    read_burst(32'h8000_003F, 32'h8000_0020, line_b, 2, 1'b0);
    chk("gap_beat_cnt", 256'(dut.beat_cnt), 256'd0);
    step();

    // reset after two read beats
    base = resp_pulses;
    bus.line_address = 32'h0000_0100;
    bus.line_read    = 1'b1;
    step();
    step();
    bus.bmem_resp  = 1'b1;
    bus.bmem_rdata = 64'hAAAA_AAAA_AAAA_AAAA;
    step();
    bus.bmem_rdata = 64'hBBBB_BBBB_BBBB_BBBB;
    step();
    bus.bmem_resp = 1'b0;
    bus.line_read = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rdata", bus.line_rdata, 256'd0);
    chk("mid_rst_address", {224'd0, bus.bmem_address}, 256'd0);
    chk("mid_rst_write", {255'd0, bus.bmem_write}, 256'd0);
    chk("mid_rst_beat_cnt", 256'(dut.beat_cnt), 256'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("mid_rst_no_resp", 256'(resp_pulses - base), 256'd0);
    read_burst(32'h0000_0100, 32'h0000_0100, line_c, 0, 1'b0);
    step();

    // line_read held through DONE starts a second burst
    read_burst(32'h0000_2000, 32'h0000_2000, line_a, 0, 1'b1);
    step();
    chk("held_idle_no_resp", {255'd0, bus.line_resp}, 256'd0);
    read_burst(32'h0000_2000, 32'h0000_2000, line_c, 1, 1'b0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/bmem_line_adapter.md
BMEM_LINE_ADAPTER -- requirements
Module: bmem_line_adapter

Interface
REQ-001 SHALL have parameter DATA_W, default 64: burst beat width in bits.
REQ-002 SHALL have parameter BEATS, default 4: beats per line; line width LINE_W = DATA_W*BEATS (256 by default).
REQ-003 SHALL have port clk  input  1: sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port line_address  input  32: upstream (cache) line address.
REQ-006 SHALL have port line_read  input  1: upstream line read request, level, held until line_resp.
REQ-007 SHALL have port line_write  input  1: upstream line write request, level, held until line_resp.
REQ-008 SHALL have port line_wdata  input  LINE_W: line to write; beat k = bits [k*DATA_W +: DATA_W].
REQ-009 SHALL have port line_rdata  output  LINE_W: assembled read line.
REQ-010 SHALL have port line_resp  output  1: one-cycle completion pulse.
REQ-011 SHALL have port bmem_address  output  32: burst address, line-aligned.
REQ-012 SHALL have port bmem_read  output  1: burst read strobe.
REQ-013 SHALL have port bmem_write  output  1: burst write strobe, one cycle per beat.
REQ-014 SHALL have port bmem_wdata  output  DATA_W: current write beat.
REQ-015 SHALL have port bmem_rdata  input  DATA_W: read beat from burst memory.
REQ-016 SHALL have port bmem_resp  input  1: read beat valid / write burst accepted.

Function
REQ-017 SHALL implement states IDLE, RD_REQ, RD_DATA, WR_DATA, WR_WAIT, DONE; all outputs registered.
REQ-018 SHALL sample requests only in IDLE; line_write has priority when line_read and line_write are both high.
REQ-019 SHALL latch address on acceptance with low log2(LINE_W/8) bits forced to zero; bmem_address holds the latched value until return to IDLE.
REQ-020 SHALL on read acceptance go IDLE->RD_REQ, driving bmem_read=1 for exactly that one cycle, then RD_DATA.
REQ-021 SHALL in RD_DATA capture bmem_rdata into beat slot beat_cnt on each cycle bmem_resp=1 and increment beat_cnt; gaps between beats are tolerated with no timeout.
REQ-022 SHALL leave RD_DATA for DONE on the cycle the beat BEATS-1 is captured; line_rdata is valid from DONE and holds until the next read capture.
REQ-023 SHALL on write acceptance latch line_wdata, enter WR_DATA and drive bmem_write=1 for BEATS consecutive cycles with bmem_wdata = beat 0,1,...,BEATS-1 in order.
REQ-024 SHALL after the last write beat enter WR_WAIT with bmem_write=0 and stay until bmem_resp=1, then enter DONE.
REQ-025 SHALL assert line_resp=1 for exactly the one cycle in DONE, then return to IDLE unconditionally.
REQ-026 SHALL treat a request still high in the IDLE cycle after DONE as a new request.
REQ-027 SHALL ignore bmem_resp in IDLE, RD_REQ, WR_DATA and DONE.
REQ-028 SHALL use a beat counter of width clog2(BEATS) that wraps to 0 at burst completion.
REQ-029 SHALL keep read latency (line_read accepted to line_resp) = 2 + cycles until the last beat arrives; minimum is BEATS+2 cycles with back-to-back beats starting the cycle after bmem_read.
REQ-030 SHALL keep write latency = BEATS + cycles in WR_WAIT + 1.

Reset
REQ-031 SHALL on rst_n=0 immediately force state=IDLE, beat_cnt=0, bmem_read=0, bmem_write=0, line_resp=0, bmem_address=0, bmem_wdata=0, line_rdata=0.
REQ-032 SHALL, if reset is asserted mid-burst, abandon the burst with no line_resp and leave partial beats unreported.
REQ-033 SHALL accept a new request in the first IDLE cycle after rst_n rises.

Verification
REQ-034 SHALL pass this scenario: read at 0x1234_5678, beats 0x11..,0x22..,0x33..,0x44.. back-to-back -> bmem_address=0x1234_5660, one-cycle bmem_read, line_rdata={0x44..,0x33..,0x22..,0x11..}, line_resp 6 cycles after acceptance.
REQ-035 SHALL pass this scenario: write line {D3,D2,D1,D0} at 0x0000_0040 with bmem_resp 3 cycles after the last beat -> bmem_write high for 4 cycles carrying D0..D3, then line_resp one cycle after bmem_resp.
REQ-036 SHALL pass this scenario: line_read and line_write both high in IDLE -> a write burst is issued and bmem_read is never asserted.
REQ-037 SHALL pass this scenario: read beats with 2-cycle gaps between each, plus a spurious bmem_resp in IDLE -> correct line assembled, spurious pulse ignored, beat_cnt=0 afterwards.
REQ-038 SHALL pass this scenario: rst_n pulled low after 2 read beats -> all outputs 0 at once, no line_resp; a subsequent read completes correctly.
REQ-039 SHALL pass this scenario: line_read held high through DONE -> a second burst starts in the following IDLE cycle.
